// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Scoreboard-based hazard and forwarding controller for the 16-bit five-stage
// pipeline. It tracks the destination register of each instruction in EX, MEM
// and WB. From that state it produces the decode stage's operand-select codes
// and its stall request.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, the block adds a saturating stall_count output. The counter
//   increments on every edge where a stall is taken.
//
// Ports:
//   clk           pipeline clock, rising edge
//   reset         asynchronous, active-high reset
//   RA, RB        decode source registers (already SRC1/SRC2-muxed)
//   useA, useB    decode instruction reads operand A / B
//   id_reg_write  decode instruction writes a register
//   id_rd         decode destination register
//   id_is_load    decode instruction is a load
//   flush         taken branch/jump kills the decode instruction this cycle
//   freeze        whole-pipeline hold (memory wait)
//   ForwardA/B    00 regfile, 01 AluResult, 10 MemoryResult, 11 WBResult
//   stall         hold PC and IF/ID, and insert a bubble into EX
//   stall_count   stall statistics (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             RA,
  input  logic [2:0]             RB,
  input  logic                   useA,
  input  logic                   useB,
  input  logic                   id_reg_write,
  input  logic [2:0]             id_rd,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic                   freeze,
  output logic [1:0]             ForwardA,
  output logic [1:0]             ForwardB,
`ifdef HAZARD_STATS_EN
  output logic [STALL_CNT_W-1:0] stall_count,
`endif
  output logic                   stall
);

  // Scoreboard entries. Index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]      sb_valid_reg;
  logic [2:0]      sb_load_reg;
  logic [2:0][2:0] sb_rd_reg;

  logic            id_valid;
  logic            ex_valid_next;
  logic [1:0]      load_hit;
  logic [1:0][1:0] fwd_sel;

  // R0 is hard-wired, so writes to it never create a dependency.
  assign id_valid      = id_reg_write && (id_rd != 3'b000);
  // A stalled or killed decode instruction enters EX as a bubble.
  assign ex_valid_next = id_valid && !stall && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_valid_reg <= '0;
      sb_load_reg  <= '0;
      sb_rd_reg    <= '0;
    end else if (!freeze) begin
      sb_valid_reg <= {sb_valid_reg[1:0], ex_valid_next};
      sb_load_reg  <= {sb_load_reg[1:0], id_is_load && ex_valid_next};
      sb_rd_reg    <= {sb_rd_reg[1:0], id_rd};
    end
  end

  // One forwarding lane per source operand: gi = 0 is A, gi = 1 is B.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_fwd
    logic [2:0] src;
    logic       use_src;
    logic [1:0] sel;

    if (gi == 0) begin : gen_a
      assign src     = RA;
      assign use_src = useA;
    end else begin : gen_b
      assign src     = RB;
      assign use_src = useB;
    end

    // Youngest producer wins. A load in EX has no data yet, so it does not
    // forward. The lane then falls through to older stages. The stall logic
    // covers that case.
    always_comb begin
      sel = 2'b00;
      if (use_src) begin
        if (sb_valid_reg[0] && (sb_rd_reg[0] == src) && !sb_load_reg[0])
          sel = 2'b01;
        else if (sb_valid_reg[1] && (sb_rd_reg[1] == src))
          sel = 2'b10;
        else if (sb_valid_reg[2] && (sb_rd_reg[2] == src))
          sel = 2'b11;
      end
    end

    assign load_hit[gi] = use_src && sb_valid_reg[0] && sb_load_reg[0] &&
                          (sb_rd_reg[0] == src);
    assign fwd_sel[gi]  = sel;
  end

  assign ForwardA = fwd_sel[0];
  assign ForwardB = fwd_sel[1];

  // A flushed instruction is being killed, so it must not stall. While
  // frozen, nothing advances, so a stall would be meaningless.
  assign stall = (|load_hit) && !flush && !freeze;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_reg <= '0;
    else if (stall && !freeze && !(&stall_count_reg))
      stall_count_reg <= stall_count_reg + 1'b1;
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed-vector bench for hazard_forward_unit. The bench changes inputs 2 time
// units after each rising edge. It samples the combinational outputs 1 time
// unit after that.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  RA, RB, id_rd;
  logic        useA, useB, id_reg_write, id_is_load, flush, freeze;
  logic [1:0]  ForwardA, ForwardB;
  logic        stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  hazard_forward_unit #(.STALL_CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA           (RA),
    .RB           (RB),
    .useA         (useA),
    .useB         (useB),
    .id_reg_write (id_reg_write),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .freeze       (freeze),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
`ifdef HAZARD_STATS_EN
    .stall_count  (stall_count),
`endif
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Apply one decode-stage vector, then let the combinational outputs settle.
  task automatic drive(input logic wr, input logic [2:0] rd, input logic ld,
                       input logic [2:0] ra, input logic ua,
                       input logic [2:0] rb, input logic ub,
                       input logic fl, input logic fz);
    id_reg_write = wr; id_rd = rd; id_is_load = ld;
    RA = ra; useA = ua; RB = rb; useB = ub;
    flush = fl; freeze = fz;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    check("reset_fa", ForwardA, 2'b00);
    check("reset_fb", ForwardB, 2'b00);
    check("reset_stall", stall, 1'b0);
`ifdef HAZARD_STATS_EN
    check("reset_cnt", stall_count, 16'd0);
`endif
    tick();
    reset = 1'b0;

    // Empty scoreboard. This instruction also writes r3 from the ALU.
    drive(1, 3, 0, 3, 1, 0, 0, 0, 0);
    check("empty_fa", ForwardA, 2'b00);
    check("empty_stall", stall, 1'b0);
    tick();
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    check("ex_fwd_fa", ForwardA, 2'b01);
    tick();
    drive(0, 0, 0, 3, 0, 0, 0, 0, 0);
    check("unused_fa", ForwardA, 2'b00);
    tick();
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    check("wb_fwd_fa", ForwardA, 2'b11);
    tick();

    // Load r5, followed by a reader of r5 that also writes r6.
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("load_issue_stall", stall, 1'b0);
    tick();
    drive(1, 6, 0, 0, 0, 5, 1, 0, 0);
    check("load_use_stall", stall, 1'b1);
    tick();
    // Held instruction. EX must now be a bubble, so r6 must not be in EX.
    drive(1, 6, 0, 6, 1, 5, 1, 0, 0);
    check("after_stall_stall", stall, 1'b0);
    check("after_stall_fb", ForwardB, 2'b10);
    check("bubble_fa", ForwardA, 2'b00);
`ifdef HAZARD_STATS_EN
    check("cnt_one", stall_count, 16'd1);
`endif
    tick();
    drive(0, 0, 0, 6, 1, 5, 1, 0, 0);
    check("r6_ex_fa", ForwardA, 2'b01);
    check("r5_wb_fb", ForwardB, 2'b11);
    tick();

    // Two consecutive writers of r2. The younger one must win.
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 2, 0, 6, 1, 0, 0, 0, 0);
    check("r6_wb_fa", ForwardA, 2'b11);
    tick();
    drive(1, 0, 0, 2, 1, 2, 1, 0, 0);
    check("youngest_fa", ForwardA, 2'b01);
    check("youngest_fb", ForwardB, 2'b01);
    tick();
    drive(0, 0, 0, 0, 1, 2, 1, 0, 0);
    check("r0_untracked_fa", ForwardA, 2'b00);
    check("r2_mem_fb", ForwardB, 2'b10);
    tick();

    // Load-use hazard in the same cycle as a flush.
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 7, 0, 4, 1, 0, 0, 1, 0);
    check("flush_stall", stall, 1'b0);
    tick();
    drive(0, 0, 0, 7, 1, 4, 1, 0, 0);
    check("flush_bubble_fa", ForwardA, 2'b00);
    check("flush_load_mem_fb", ForwardB, 2'b10);
    tick();

    // Load-use hazard while frozen. The scoreboard must hold.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 3, 0, 1, 1, 1, 1, 0, 1);
    check("freeze_stall", stall, 1'b0);
    tick();
    drive(1, 3, 0, 1, 1, 1, 1, 0, 0);
    check("freeze_held_stall", stall, 1'b1);
`ifdef HAZARD_STATS_EN
    check("cnt_no_flush_freeze", stall_count, 16'd1);
`endif

    // Asynchronous reset in the middle of the stall.
    reset = 1'b1;
    #1;
    check("midreset_fa", ForwardA, 2'b00);
    check("midreset_fb", ForwardB, 2'b00);
    check("midreset_stall", stall, 1'b0);
`ifdef HAZARD_STATS_EN
    check("midreset_cnt", stall_count, 16'd0);
`endif
    // Release the reset before the next edge. That edge captures the decode entry.
    reset = 1'b0;
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 5, 1, 0, 0, 0, 0);
    check("post_reset_fa", ForwardA, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Scoreboard-based hazard and forwarding controller for the 16-bit five-stage pipeline. It tracks the destination registers of instructions in flight in EX, MEM and WB, and drives the decode stage's `ForwardA`/`ForwardB` operand-select codes and its `stall` input. It is the control-side counterpart of the decode stage: decode consumes operands, and this block decides where each operand comes from and when decode must hold.

## Interface
- `STALL_CNT_W`, 16: width of the stall statistics counter (used only with `HAZARD_STATS_EN`).
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `RA` in 3: decode source register A (already SRC1-muxed).
- `RB` in 3: decode source register B (already SRC2-muxed).
- `useA` in 1: the decode instruction reads operand A.
- `useB` in 1: the decode instruction reads operand B.
- `id_reg_write` in 1: the decode instruction writes a register.
- `id_rd` in 3: decode destination (`RD2`).
- `id_is_load` in 1: the decode instruction is a load.
- `flush` in 1: a taken branch or jump kills the decode instruction this cycle.
- `freeze` in 1: external whole-pipeline hold (memory wait).
- `ForwardA` out 2: select for A. `00` = regfile, `01` = AluResult, `10` = MemoryResult, `11` = WBResult.
- `ForwardB` out 2: select for B, same encoding as `ForwardA`.
- `stall` out 1: hold PC and the IF/ID register, and insert a bubble into EX.
- `stall_count` out `STALL_CNT_W`: present only with `HAZARD_STATS_EN`.

## Operation
- Scoreboard: three entries, `EX`, `MEM` and `WB`. Each entry holds `{valid, rd[2:0], is_load}`. All entries are invalid after reset.
- Each rising edge, unless `freeze` is high:
  - `WB` ← `MEM`
  - `MEM` ← `EX`
  - `EX` ← the decode entry, or a bubble if `stall` or `flush` is high.
- Decode entry: `valid = id_reg_write && id_rd != 3'b000`. R0 is never tracked.
- Forward select for operand A (same rule for B with `RB`/`useB`). The first match wins:
  - If `!useA` → `00`.
  - EX valid, `rd==RA`, not a load → `01`.
  - MEM valid, `rd==RA` → `10`.
  - WB valid, `rd==RA` → `11`.
  - Otherwise → `00`.
- Load-use hazard: EX valid, EX is a load, and it matches a used source → `stall=1`. Forward codes are don't-care while stalled; drive them as computed.
- `stall` is forced to 0 when `flush` or `freeze` is high. Flush wins over stall because the stalled instruction is being killed.
- `freeze` holds the scoreboard and suppresses `stall`. Forward codes stay combinational on the held state.

## Timing
- `ForwardA`, `ForwardB` and `stall` are combinational from the current inputs and the registered scoreboard. There is zero-cycle latency within the decode cycle.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and the operand forwards with `10`.
- After two back-to-back writers of the same register, the younger one (EX) wins with `01`.
- Reset values: `ForwardA=00`, `ForwardB=00`, `stall=0`, `stall_count=0`, all scoreboard entries invalid.
- Asserting `reset` mid-stall clears everything immediately. The first edge after release captures the current decode entry.

## Configuration
- `HAZARD_STATS_EN` defined:
  - Adds the `stall_count` port.
  - The counter increments on every edge where `stall=1` and `freeze=0`.
  - It saturates at all-ones.
  - It clears only on `reset`.
- `HAZARD_STATS_EN` undefined: no port and no counter logic. Forwarding and stall behaviour is identical in both builds.

## Test plan
- Reset, then decode `RA=3`, `useA=1` with an empty scoreboard → `ForwardA=00`, `stall=0`.
- ALU writer `rd=3`, then the next instruction reads `RA=3` → `ForwardA=01`. Two cycles later the same read gives `11`.
- Load `rd=5`, then the next instruction reads `RB=5`:
  - Cycle 1: `stall=1`, and EX receives a bubble.
  - Cycle 2: `stall=0`, `ForwardB=10`.
  - With `HAZARD_STATS_EN`, `stall_count=1`.
- Writers `rd=2` in EX and `rd=2` in MEM, decode reads `RA=2` → `01`. Writer to R0, then a read of R0 → `00`.
- Load-use hazard with `flush=1` in the same cycle → `stall=0`, and EX gets a bubble. Load-use hazard with `freeze=1` → `stall=0`, and the scoreboard is unchanged on the next edge.
- Assert `reset` while `stall=1` → on the same cycle, outputs are `00`/`00`/`0` and the counter reads 0.
